// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
interface memory_stage_if #(
  parameter int XLEN = 64
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wstrb;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage: load/store over req/ack, load extension, MEMWB bundle
module memory_stage #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EXMEM_valid,
  output logic              EXMEM_ready,
  input  logic [RIDX_W-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_aluresult,
  input  logic [XLEN-1:0]   ex_storedata,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_regwrite,
  input  logic [2:0]        ex_funct3,
  memory_stage_if.master    dmem,
  output logic [RIDX_W-1:0] dest_reg,
  output logic [XLEN-1:0]   mewb_aluresult,
  output logic [XLEN-1:0]   memwb_loadeddata,
  output logic              dataselect,
  output logic              MEMWB_ready,
  output logic              mem_fault
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [RIDX_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]     alu_q, alu_d;
  logic                memread_q, memread_d;
  logic                regwrite_q, regwrite_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [7:0]          wstrb_q, wstrb_d;
  logic [RIDX_W-1:0]   dest_reg_q, dest_reg_d;
  logic [XLEN-1:0]     aluresult_q, aluresult_d;
  logic [XLEN-1:0]     loaded_q, loaded_d;
  logic                dataselect_q, dataselect_d;
  logic                memwb_ready_q, memwb_ready_d;
  logic                mem_fault_q, mem_fault_d;

  logic                is_mem_op;
  logic [2:0]          off;
  logic                misaligned;
  logic [XLEN-1:0]     wdata_rep;
  logic [7:0]          strb_base;
  logic [XLEN-1:0]     lane;
  logic [XLEN-1:0]     load_ext;

  assign is_mem_op = ex_memread | ex_memwrite;
  assign off       = ex_aluresult[2:0];
  assign lane      = dmem.dmem_rdata >> {alu_q[2:0], 3'b000};

  // Alignment check, store lane replication and byte-enable base for the incoming op
  always_comb begin
    misaligned = 1'b0;
    wdata_rep  = ex_storedata;
    strb_base  = 8'hFF;
    case (ex_funct3[1:0])
      2'd0: begin misaligned = 1'b0;     wdata_rep = {(XLEN/8){ex_storedata[7:0]}};  strb_base = 8'h01; end
      2'd1: begin misaligned = off[0];   wdata_rep = {(XLEN/16){ex_storedata[15:0]}}; strb_base = 8'h03; end
      2'd2: begin misaligned = |off[1:0]; wdata_rep = {(XLEN/32){ex_storedata[31:0]}}; strb_base = 8'h0F; end
      default: begin misaligned = |off;  wdata_rep = ex_storedata;                   strb_base = 8'hFF; end
    endcase
  end

  // Size/sign extension of the addressed lane of the returned doubleword
  always_comb begin
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state: accept in IDLE, complete non-memory ops and faults at once, wait for ack in ACCESS
  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    alu_d         = alu_q;
    memread_d     = memread_q;
    regwrite_d    = regwrite_q;
    funct3_d      = funct3_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    dest_reg_d    = dest_reg_q;
    aluresult_d   = aluresult_q;
    loaded_d      = loaded_q;
    dataselect_d  = dataselect_q;
    memwb_ready_d = 1'b0;
    mem_fault_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (EXMEM_valid) begin
          rd_d       = ex_rd;
          alu_d      = ex_aluresult;
          memread_d  = ex_memread;
          regwrite_d = ex_regwrite;
          funct3_d   = ex_funct3;
          if (!is_mem_op) begin
            if (ex_regwrite) begin
              memwb_ready_d = 1'b1;
              dest_reg_d    = ex_rd;
              aluresult_d   = ex_aluresult;
              dataselect_d  = 1'b0;
            end
          end else if (misaligned || ex_funct3 == 3'b111) begin
            mem_fault_d = 1'b1;
          end else begin
            state_d = ACCESS;
            addr_d  = {ex_aluresult[XLEN-1:3], 3'b000};
            we_d    = ~ex_memread;
            wdata_d = wdata_rep;
            wstrb_d = strb_base << off;
          end
        end
      end
      default: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          if (regwrite_q && memread_q) begin
            memwb_ready_d = 1'b1;
            dest_reg_d    = rd_q;
            aluresult_d   = alu_q;
            loaded_d      = load_ext;
            dataselect_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // State and output registers; async reset also drops an in-flight request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rd_q          <= '0;
      alu_q         <= '0;
      memread_q     <= 1'b0;
      regwrite_q    <= 1'b0;
      funct3_q      <= 3'b000;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= 8'h00;
      dest_reg_q    <= '0;
      aluresult_q   <= '0;
      loaded_q      <= '0;
      dataselect_q  <= 1'b0;
      memwb_ready_q <= 1'b0;
      mem_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      alu_q         <= alu_d;
      memread_q     <= memread_d;
      regwrite_q    <= regwrite_d;
      funct3_q      <= funct3_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      dest_reg_q    <= dest_reg_d;
      aluresult_q   <= aluresult_d;
      loaded_q      <= loaded_d;
      dataselect_q  <= dataselect_d;
      memwb_ready_q <= memwb_ready_d;
      mem_fault_q   <= mem_fault_d;
    end
  end

  assign EXMEM_ready      = (state_q == IDLE);
  assign dmem.dmem_req    = (state_q == ACCESS);
  assign dmem.dmem_we     = we_q;
  assign dmem.dmem_addr   = addr_q;
  assign dmem.dmem_wdata  = wdata_q;
  assign dmem.dmem_wstrb  = wstrb_q;
  assign dest_reg         = dest_reg_q;
  assign mewb_aluresult   = aluresult_q;
  assign memwb_loadeddata = loaded_q;
  assign dataselect       = dataselect_q;
  assign MEMWB_ready      = memwb_ready_q;
  assign mem_fault        = mem_fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXMEM_valid;
  logic        EXMEM_ready;
  logic [5:0]  ex_rd;
  logic [63:0] ex_aluresult;
  logic [63:0] ex_storedata;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_regwrite;
  logic [2:0]  ex_funct3;
  logic [5:0]  dest_reg;
  logic [63:0] mewb_aluresult;
  logic [63:0] memwb_loadeddata;
  logic        dataselect;
  logic        MEMWB_ready;
  logic        mem_fault;

  memory_stage_if #(.XLEN(64)) dmem_bus ();

  memory_stage #(.XLEN(64), .RIDX_W(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .EXMEM_valid      (EXMEM_valid),
    .EXMEM_ready      (EXMEM_ready),
    .ex_rd            (ex_rd),
    .ex_aluresult     (ex_aluresult),
    .ex_storedata     (ex_storedata),
    .ex_memread       (ex_memread),
    .ex_memwrite      (ex_memwrite),
    .ex_regwrite      (ex_regwrite),
    .ex_funct3        (ex_funct3),
    .dmem             (dmem_bus),
    .dest_reg         (dest_reg),
    .mewb_aluresult   (mewb_aluresult),
    .memwb_loadeddata (memwb_loadeddata),
    .dataselect       (dataselect),
    .MEMWB_ready      (MEMWB_ready),
    .mem_fault        (mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  rd;
    logic [63:0] alu;
    logic [63:0] sd;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [2:0]  f3;
    logic [63:0] rdata;
    int          delay;
    logic        exp_fault;
    logic        exp_pulse;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_load;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [5:0]  exp_dest;
  logic [63:0] exp_alu;
  logic [63:0] exp_load;
  logic        exp_dsel;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] rd, input logic [63:0] alu, input logic [63:0] sd,
                              input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                              input logic [63:0] rdata, input int delay, input logic ef, input logic ep,
                              input logic [7:0] es, input logic [63:0] ew, input logic [63:0] el);
    vec_t v;
    v.rd = rd; v.alu = alu; v.sd = sd; v.mr = mr; v.mw = mw; v.rw = rw; v.f3 = f3;
    v.rdata = rdata; v.delay = delay; v.exp_fault = ef; v.exp_pulse = ep;
    v.exp_strb = es; v.exp_wdata = ew; v.exp_load = el;
    return v;
  endfunction

  // Reference model: access size in bytes, byte offset, masks and byte-by-byte replication
  function automatic vec_t model(input vec_t v);
    int          bytes;
    int          off;
    logic        is_mem;
    logic [63:0] val;
    logic [63:0] mask;
    bytes = 1 << v.f3[1:0];
    off   = int'(v.alu[2:0]);
    is_mem = v.mr || v.mw;
    v.exp_fault = is_mem && (((off % bytes) != 0) || (v.f3 == 3'b111));
    v.exp_pulse = v.rw && !v.exp_fault && (!is_mem || v.mr);
    v.exp_strb  = 8'(((1 << bytes) - 1) << off);
    for (int i = 0; i < 8; i++) v.exp_wdata[8*i +: 8] = v.sd[8*(i % bytes) +: 8];
    mask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*bytes)) - 64'd1);
    val  = (v.rdata >> (8*off)) & mask;
    if (!v.f3[2] && bytes < 8 && val[8*bytes-1]) val = val | ~mask;
    v.exp_load = val;
    return v;
  endfunction

  task automatic check_held();
    chk("dest_reg", 64'(dest_reg), 64'(exp_dest));
    chk("mewb_aluresult", mewb_aluresult, exp_alu);
    chk("memwb_loadeddata", memwb_loadeddata, exp_load);
    chk("dataselect", 64'(dataselect), 64'(exp_dsel));
  endtask

  // Apply one op at a negedge and follow it through to completion
  task automatic run_op(input vec_t v, input string tag);
    chk({tag, "_accept_ready"}, 64'(EXMEM_ready), 64'd1);
    EXMEM_valid = 1'b1; ex_rd = v.rd; ex_aluresult = v.alu; ex_storedata = v.sd;
    ex_memread = v.mr; ex_memwrite = v.mw; ex_regwrite = v.rw; ex_funct3 = v.f3;
    @(negedge clk);
    EXMEM_valid = 1'b0;
    ex_aluresult = 64'(~v.alu); ex_storedata = 64'(~v.sd); ex_rd = 6'(~v.rd);
    if (!v.mr && !v.mw) begin
      chk({tag, "_alu_pulse"}, 64'(MEMWB_ready), 64'(v.exp_pulse));
      chk({tag, "_alu_fault"}, 64'(mem_fault), 64'd0);
      chk({tag, "_alu_req"}, 64'(dmem_bus.dmem_req), 64'd0);
      if (v.exp_pulse) begin exp_dest = v.rd; exp_alu = v.alu; exp_dsel = 1'b0; end
    end else if (v.exp_fault) begin
      chk({tag, "_fault"}, 64'(mem_fault), 64'd1);
      chk({tag, "_fault_req"}, 64'(dmem_bus.dmem_req), 64'd0);
      chk({tag, "_fault_pulse"}, 64'(MEMWB_ready), 64'd0);
      chk({tag, "_fault_ready"}, 64'(EXMEM_ready), 64'd1);
    end else begin
      chk({tag, "_req"}, 64'(dmem_bus.dmem_req), 64'd1);
      chk({tag, "_busy"}, 64'(EXMEM_ready), 64'd0);
      chk({tag, "_addr"}, dmem_bus.dmem_addr, {v.alu[63:3], 3'b000});
      chk({tag, "_we"}, 64'(dmem_bus.dmem_we), 64'(v.mw && !v.mr));
      if (v.mw && !v.mr) begin
        chk({tag, "_wstrb"}, 64'(dmem_bus.dmem_wstrb), 64'(v.exp_strb));
        chk({tag, "_wdata"}, dmem_bus.dmem_wdata, v.exp_wdata);
      end
      repeat (v.delay) @(negedge clk);
      chk({tag, "_req_held"}, 64'(dmem_bus.dmem_req), 64'd1);
      chk({tag, "_addr_held"}, dmem_bus.dmem_addr, {v.alu[63:3], 3'b000});
      chk({tag, "_early_pulse"}, 64'(MEMWB_ready), 64'd0);
      dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = v.rdata;
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = {$urandom, $urandom};
      chk({tag, "_ack_pulse"}, 64'(MEMWB_ready), 64'(v.exp_pulse));
      chk({tag, "_ack_req"}, 64'(dmem_bus.dmem_req), 64'd0);
      chk({tag, "_ack_ready"}, 64'(EXMEM_ready), 64'd1);
      if (v.exp_pulse) begin exp_dest = v.rd; exp_alu = v.alu; exp_load = v.exp_load; exp_dsel = 1'b1; end
    end
    check_held();
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    reset = 1'b0; EXMEM_valid = 1'b0; ex_rd = '0; ex_aluresult = '0; ex_storedata = '0;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_regwrite = 1'b0; ex_funct3 = 3'b000;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    exp_dest = '0; exp_alu = '0; exp_load = '0; exp_dsel = 1'b0;

    tbl[0]  = mk(6'd5,  64'h1234, 64'h0, 0,0,1, 3'b000, 64'h0, 0, 0,1, 8'h00, 64'h0, 64'h0);
    tbl[1]  = mk(6'd7,  64'h1003, 64'h0, 1,0,1, 3'b000, 64'h00000000_80000000, 3, 0,1, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80);
    tbl[2]  = mk(6'd8,  64'h1006, 64'h0, 1,0,1, 3'b101, 64'hBEEF0000_00000000, 1, 0,1, 8'h00, 64'h0, 64'h00000000_0000BEEF);
    tbl[3]  = mk(6'd9,  64'h2004, 64'hCAFEBABE, 0,1,1, 3'b010, 64'h0, 2, 0,0, 8'hF0, 64'hCAFEBABE_CAFEBABE, 64'h0);
    tbl[4]  = mk(6'd10, 64'h2002, 64'h0, 1,0,1, 3'b010, 64'h0, 0, 1,0, 8'h00, 64'h0, 64'h0);
    tbl[5]  = mk(6'd11, 64'h3000, 64'h0, 1,0,1, 3'b011, 64'h01234567_89ABCDEF, 0, 0,1, 8'h00, 64'h0, 64'h01234567_89ABCDEF);
    tbl[6]  = mk(6'd12, 64'h3004, 64'h0, 1,0,1, 3'b110, 64'h89ABCDEF_00000000, 1, 0,1, 8'h00, 64'h0, 64'h00000000_89ABCDEF);
    tbl[7]  = mk(6'd13, 64'h3004, 64'h0, 1,0,1, 3'b010, 64'h89ABCDEF_00000000, 2, 0,1, 8'h00, 64'h0, 64'hFFFFFFFF_89ABCDEF);
    tbl[8]  = mk(6'd14, 64'h4005, 64'h11223344_556677A5, 0,1,1, 3'b000, 64'h0, 0, 0,0, 8'h20, 64'hA5A5A5A5_A5A5A5A5, 64'h0);
    tbl[9]  = mk(6'd15, 64'h4001, 64'h0, 0,1,0, 3'b011, 64'h0, 0, 1,0, 8'h00, 64'h0, 64'h0);
    tbl[10] = mk(6'd16, 64'h5000, 64'h0, 1,0,1, 3'b111, 64'h0, 0, 1,0, 8'h00, 64'h0, 64'h0);
    tbl[11] = mk(6'd20, 64'hDEAD, 64'h0, 0,0,1, 3'b111, 64'h0, 0, 0,1, 8'h00, 64'h0, 64'h0);
    tbl[12] = mk(6'd21, 64'h1002, 64'h0, 1,1,1, 3'b001, 64'h00000000_80010000, 1, 0,1, 8'h00, 64'h0, 64'hFFFFFFFF_FFFF8001);
    tbl[13] = mk(6'd22, 64'h6006, 64'h1234BEEF, 0,1,1, 3'b001, 64'h0, 1, 0,0, 8'hC0, 64'hBEEFBEEF_BEEFBEEF, 64'h0);
    tbl[14] = mk(6'd23, 64'h7000, 64'h0, 1,0,0, 3'b000, 64'h55, 0, 0,0, 8'h00, 64'h0, 64'h55);
    tbl[15] = mk(6'd24, 64'h9999, 64'h0, 0,0,0, 3'b000, 64'h0, 0, 0,0, 8'h00, 64'h0, 64'h0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_exmem_ready", 64'(EXMEM_ready), 64'd1);
    chk("rst_req", 64'(dmem_bus.dmem_req), 64'd0);
    chk("rst_pulse", 64'(MEMWB_ready), 64'd0);
    chk("rst_fault", 64'(mem_fault), 64'd0);
    chk("rst_wstrb", 64'(dmem_bus.dmem_wstrb), 64'd0);
    check_held();
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back ALU ops at one per cycle
    EXMEM_valid = 1'b1; ex_memread = 1'b0; ex_memwrite = 1'b0; ex_regwrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_rd = 6'(30 + i); ex_aluresult = 64'(64'hA000 + i);
      @(negedge clk);
      chk("b2b_pulse", 64'(MEMWB_ready), 64'd1);
      chk("b2b_ready", 64'(EXMEM_ready), 64'd1);
      chk("b2b_dest", 64'(dest_reg), 64'(30 + i));
      chk("b2b_alu", mewb_aluresult, 64'(64'hA000 + i));
    end
    EXMEM_valid = 1'b0;
    exp_dest = 6'd33; exp_alu = 64'hA003; exp_dsel = 1'b0;
    @(negedge clk);
    chk("b2b_idle_pulse", 64'(MEMWB_ready), 64'd0);
    check_held();

    // Reset in the middle of an access, then a stray ack
    EXMEM_valid = 1'b1; ex_rd = 6'd3; ex_aluresult = 64'h8000; ex_memread = 1'b1;
    ex_memwrite = 1'b0; ex_regwrite = 1'b1; ex_funct3 = 3'b011;
    @(negedge clk);
    EXMEM_valid = 1'b0;
    chk("mid_req_before", 64'(dmem_bus.dmem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_req_dropped", 64'(dmem_bus.dmem_req), 64'd0);
    chk("mid_ready", 64'(EXMEM_ready), 64'd1);
    exp_dest = '0; exp_alu = '0; exp_load = '0; exp_dsel = 1'b0;
    check_held();
    @(negedge clk);
    reset = 1'b1;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    dmem_bus.dmem_ack = 1'b0;
    chk("stray_ack_pulse", 64'(MEMWB_ready), 64'd0);
    chk("stray_ack_req", 64'(dmem_bus.dmem_req), 64'd0);
    chk("stray_ack_ready", 64'(EXMEM_ready), 64'd1);
    check_held();

    // Randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      int kind;
      rv.rd = 6'($urandom); rv.alu = {$urandom, $urandom}; rv.sd = {$urandom, $urandom};
      rv.rdata = {$urandom, $urandom}; rv.f3 = 3'($urandom); rv.rw = 1'($urandom);
      rv.delay = int'($urandom_range(0, 4));
      kind = int'($urandom_range(0, 3));
      rv.mr = (kind == 1) || (kind == 3);
      rv.mw = (kind == 2) || (kind == 3);
      if ($urandom_range(0, 2) != 0) rv.alu[2:0] = rv.alu[2:0] & ~3'((1 << rv.f3[1:0]) - 1);
      rv = model(rv);
      run_op(rv, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
